// File: rtl/threat_response_ctrl.sv
// threat_response_ctrl
// Confirms persistent per-type threat flags, queues newly confirmed threats
// as pending, and dispatches them one at a time (lowest index first) to a
// countermeasure unit over a valid/ready handshake, followed by a fixed
// cooldown. Optional feature macro: THREAT_STATS_EN (handshake counter on
// dispatch_count; tied to zero when undefined).
module threat_response_ctrl #(
    parameter int PERSIST  = 3,
    parameter int COOLDOWN = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  threat_vector,
    input  logic        cm_ready,
    output logic        cm_valid,
    output logic [2:0]  cm_code,
    output logic [7:0]  confirmed,
    output logic [7:0]  pending,
    output logic        alert,
    output logic [1:0]  state,
    output logic [15:0] dispatch_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_DISPATCH = 2'd1,
        S_COOLDOWN = 2'd2
    } state_t;

    localparam logic [3:0] PERSIST_C  = 4'(PERSIST);
    localparam logic [7:0] COOLDOWN_C = 8'(COOLDOWN);

    state_t      state_reg, state_next;
    logic [2:0]  code_next;
    logic [7:0]  cd_reg, cd_next;
    logic [3:0]  cnt_reg  [8];
    logic [3:0]  cnt_next [8];
    logic [7:0]  conf_next;
    logic [7:0]  rise;
    logic [7:0]  clr;
    logic [7:0]  pending_next;
    logic        handshake;
    logic [2:0]  sel;

    // Per-bit persistence counters; confirmation follows the counter's next value
    // so confirmed rises on the very edge the counter reaches PERSIST.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_persist
            // Saturating count while the flag is high, clear when it drops.
            always_comb begin
                cnt_next[gi] = 4'd0;
                if (threat_vector[gi]) begin
                    cnt_next[gi] = (cnt_reg[gi] >= PERSIST_C) ? PERSIST_C : cnt_reg[gi] + 4'd1;
                end
            end

            assign conf_next[gi] = (cnt_next[gi] == PERSIST_C);

            // Counter register.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) cnt_reg[gi] <= 4'd0;
                else       cnt_reg[gi] <= cnt_next[gi];
            end
        end
    endgenerate

    // Pending arms only on a fresh confirmation; the handshake clears the
    // dispatched index, but a same-edge re-arm takes precedence.
    assign handshake    = (state_reg == S_DISPATCH) && cm_ready;
    assign rise         = conf_next & ~confirmed;
    assign clr          = handshake ? (8'd1 << cm_code) : 8'd0;
    assign pending_next = (pending & ~clr) | rise;

    // Lowest set pending index wins.
    always_comb begin
        sel = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) sel = 3'(i);
        end
    end

    // Next-state logic: dispatch command stays frozen until the handshake.
    always_comb begin
        state_next = state_reg;
        code_next  = cm_code;
        cd_next    = cd_reg;
        unique case (state_reg)
            S_IDLE: begin
                if (pending != 8'd0) begin
                    code_next  = sel;
                    state_next = S_DISPATCH;
                end
            end
            S_DISPATCH: begin
                if (cm_ready) begin
                    cd_next    = COOLDOWN_C;
                    state_next = S_COOLDOWN;
                end
            end
            S_COOLDOWN: begin
                if (cd_reg <= 8'd1) begin
                    cd_next    = 8'd0;
                    state_next = S_IDLE;
                end else begin
                    cd_next = cd_reg - 8'd1;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, command, cooldown, confirmation and pending registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_IDLE;
            cm_code   <= 3'd0;
            cd_reg    <= 8'd0;
            confirmed <= 8'd0;
            pending   <= 8'd0;
            alert     <= 1'b0;
        end else begin
            state_reg <= state_next;
            cm_code   <= code_next;
            cd_reg    <= cd_next;
            confirmed <= conf_next;
            pending   <= pending_next;
            alert     <= |confirmed;
        end
    end

    assign cm_valid = (state_reg == S_DISPATCH);
    assign state    = state_reg;

`ifdef THREAT_STATS_EN
    logic [15:0] dc_reg;

    // Saturating handshake counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                               dc_reg <= 16'd0;
        else if (handshake && dc_reg != 16'hFFFF) dc_reg <= dc_reg + 16'd1;
    end

    assign dispatch_count = dc_reg;
`else
    assign dispatch_count = 16'h0000;
`endif

endmodule

// File: tb/tb_threat_response_ctrl.sv
// Directed bench for threat_response_ctrl (PERSIST=3, COOLDOWN=8).
module tb_threat_response_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  threat_vector;
    logic        cm_ready;
    logic        cm_valid;
    logic [2:0]  cm_code;
    logic [7:0]  confirmed;
    logic [7:0]  pending;
    logic        alert;
    logic [1:0]  state;
    logic [15:0] dispatch_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [15:0] exp_dc = 16'd0;

    threat_response_ctrl #(.PERSIST(3), .COOLDOWN(8)) dut (
        .clk(clk), .reset(reset), .threat_vector(threat_vector),
        .cm_ready(cm_ready), .cm_valid(cm_valid), .cm_code(cm_code),
        .confirmed(confirmed), .pending(pending), .alert(alert),
        .state(state), .dispatch_count(dispatch_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tv;
        logic       rdy;
        logic [7:0] conf;
        logic [7:0] pend;
        logic       valid;
        logic [2:0] code;
        logic [1:0] st;
        logic       al;
    } vec_t;

    vec_t vecs [16];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk_core(input string tag, input logic [7:0] conf, input logic [7:0] pend,
                            input logic valid, input logic [2:0] code, input logic [1:0] st);
        chk({tag, ".confirmed"}, 16'(confirmed), 16'(conf));
        chk({tag, ".pending"},   16'(pending),   16'(pend));
        chk({tag, ".cm_valid"},  16'(cm_valid),  16'(valid));
        chk({tag, ".cm_code"},   16'(cm_code),   16'(code));
        chk({tag, ".state"},     16'(state),     16'(st));
        chk({tag, ".dispatch_count"}, dispatch_count, exp_dc);
    endtask

    task automatic hs_done();
`ifdef THREAT_STATS_EN
        exp_dc = exp_dc + 16'd1;
`endif
    endtask

    task automatic step(input logic [7:0] t, input logic r);
        threat_vector = t;
        cm_ready      = r;
        @(posedge clk);
        #1;
        cyc++;
        $display("cyc=%0d tv=%02h rdy=%0b -> st=%0d valid=%0b code=%0d conf=%02h pend=%02h alert=%0b dc=%0d",
                 cyc, t, r, state, cm_valid, cm_code, confirmed, pending, alert, dispatch_count);
    endtask

    task automatic do_reset();
        threat_vector = 8'h00;
        cm_ready      = 1'b0;
        reset         = 1'b1;
        exp_dc        = 16'd0;
        #1;
        chk_core("reset", 8'h00, 8'h00, 1'b0, 3'd0, 2'd0);
        chk("reset.alert", 16'(alert), 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        // Persistence / first dispatch / cooldown length, one row per edge.
        vecs[0]  = '{8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 2'd0, 1'b0};
        vecs[1]  = '{8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 2'd0, 1'b0};
        vecs[2]  = '{8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 2'd0, 1'b0};
        vecs[3]  = '{8'h01, 1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 2'd0, 1'b0};
        vecs[4]  = '{8'h01, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 2'd0, 1'b0};
        vecs[5]  = '{8'h01, 1'b0, 8'h01, 8'h01, 1'b0, 3'd0, 2'd0, 1'b0};
        vecs[6]  = '{8'h01, 1'b0, 8'h01, 8'h01, 1'b1, 3'd0, 2'd1, 1'b1};
        vecs[7]  = '{8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 2'd2, 1'b1};
        vecs[8]  = '{8'h00, 1'b1, 8'h00, 8'h00, 1'b0, 3'd0, 2'd2, 1'b0};
        for (int i = 9; i < 15; i++)
            vecs[i] = '{8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 2'd2, 1'b0};
        vecs[15] = '{8'h00, 1'b0, 8'h00, 8'h00, 1'b0, 3'd0, 2'd0, 1'b0};

        do_reset();

        for (int i = 0; i < 16; i++) begin
            step(vecs[i].tv, vecs[i].rdy);
            if (i == 7) hs_done();
            chk_core($sformatf("vec%0d", i), vecs[i].conf, vecs[i].pend,
                     vecs[i].valid, vecs[i].code, vecs[i].st);
            chk($sformatf("vec%0d.alert", i), 16'(alert), 16'(vecs[i].al));
        end

        // Priority and stall: bits 3 and 7 together, ready held low.
        do_reset();
        step(8'h88, 1'b0);
        step(8'h88, 1'b0);
        chk_core("prio.pre", 8'h00, 8'h00, 1'b0, 3'd0, 2'd0);
        step(8'h88, 1'b0);
        chk_core("prio.conf", 8'h88, 8'h88, 1'b0, 3'd0, 2'd0);
        for (int i = 0; i < 5; i++) begin
            step(8'h88, 1'b0);
            chk_core($sformatf("prio.stall%0d", i), 8'h88, 8'h88, 1'b1, 3'd3, 2'd1);
        end
        step(8'h88, 1'b1);
        hs_done();
        chk_core("prio.hs3", 8'h88, 8'h80, 1'b0, 3'd3, 2'd2);
        for (int i = 0; i < 7; i++) begin
            step(8'h88, 1'b0);
            chk_core($sformatf("prio.cool%0d", i), 8'h88, 8'h80, 1'b0, 3'd3, 2'd2);
        end
        step(8'h88, 1'b0);
        chk_core("prio.idle", 8'h88, 8'h80, 1'b0, 3'd3, 2'd0);
        step(8'h88, 1'b0);
        chk_core("prio.disp7", 8'h88, 8'h80, 1'b1, 3'd7, 2'd1);
        step(8'h88, 1'b1);
        hs_done();
        chk_core("prio.hs7", 8'h88, 8'h00, 1'b0, 3'd7, 2'd2);

        // Same-edge set/clear on index 2, then a third handshake for statistics.
        do_reset();
        for (int i = 0; i < 3; i++) step(8'h04, 1'b0);
        chk_core("same.conf", 8'h04, 8'h04, 1'b0, 3'd0, 2'd0);
        step(8'h04, 1'b0);
        chk_core("same.disp", 8'h04, 8'h04, 1'b1, 3'd2, 2'd1);
        step(8'h00, 1'b0);
        chk_core("same.drop", 8'h00, 8'h04, 1'b1, 3'd2, 2'd1);
        step(8'h04, 1'b0);
        step(8'h04, 1'b0);
        chk_core("same.rebuild", 8'h00, 8'h04, 1'b1, 3'd2, 2'd1);
        step(8'h04, 1'b1);
        hs_done();
        chk_core("same.hs", 8'h04, 8'h04, 1'b0, 3'd2, 2'd2);
        for (int i = 0; i < 7; i++) step(8'h04, 1'b0);
        chk_core("same.coolend", 8'h04, 8'h04, 1'b0, 3'd2, 2'd2);
        step(8'h04, 1'b0);
        chk_core("same.idle", 8'h04, 8'h04, 1'b0, 3'd2, 2'd0);
        step(8'h04, 1'b0);
        chk_core("same.redisp", 8'h04, 8'h04, 1'b1, 3'd2, 2'd1);
        step(8'h04, 1'b1);
        hs_done();
        chk_core("same.hs2", 8'h04, 8'h00, 1'b0, 3'd2, 2'd2);
        for (int i = 0; i < 8; i++) step(8'h00, 1'b0);
        chk_core("stats.idle", 8'h00, 8'h00, 1'b0, 3'd2, 2'd0);
        for (int i = 0; i < 3; i++) step(8'h10, 1'b0);
        step(8'h10, 1'b0);
        chk_core("stats.disp4", 8'h10, 8'h10, 1'b1, 3'd4, 2'd1);
        step(8'h10, 1'b1);
        hs_done();
        chk_core("stats.hs3", 8'h10, 8'h00, 1'b0, 3'd4, 2'd2);

        // Asynchronous reset while dispatching with two bits pending.
        do_reset();
        for (int i = 0; i < 4; i++) step(8'h06, 1'b0);
        chk_core("rst.disp", 8'h06, 8'h06, 1'b1, 3'd1, 2'd1);
        #2;
        reset  = 1'b1;
        exp_dc = 16'd0;
        #1;
        chk_core("rst.async", 8'h00, 8'h00, 1'b0, 3'd0, 2'd0);
        chk("rst.async.alert", 16'(alert), 16'd0);
        threat_vector = 8'h00;
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(8'h00, 1'b1);
            chk_core($sformatf("rst.after%0d", i), 8'h00, 8'h00, 1'b0, 3'd0, 2'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/threat_response_ctrl.md
THREAT_RESPONSE_CTRL -- requirements
Module: threat_response_ctrl

Interface
REQ-001 SHALL have parameter PERSIST, default 3, meaning the consecutive samples a threat bit must be high before it is confirmed; legal range 1..15.
REQ-002 SHALL have parameter COOLDOWN, default 8, meaning the idle cycles after each dispatch handshake; legal range 1..255.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, asynchronous, active-high.
REQ-005 SHALL have port threat_vector, input, 8 bits: registered per-type threat flags from the signal monitor stage.
REQ-006 SHALL have port cm_ready, input, 1 bit: countermeasure unit can accept a command.
REQ-007 SHALL have port cm_valid, output, 1 bit: a countermeasure command is offered.
REQ-008 SHALL have port cm_code, output, 3 bits: index of the threat being dispatched.
REQ-009 SHALL have port confirmed, output, 8 bits: per-bit persistence-confirmed threats.
REQ-010 SHALL have port pending, output, 8 bits: confirmed threats not yet dispatched.
REQ-011 SHALL have port alert, output, 1 bit: registered OR of confirmed.
REQ-012 SHALL have port state, output, 2 bits: FSM state, with IDLE=0, DISPATCH=1, COOLDOWN=2.
REQ-013 SHALL have port dispatch_count, output, 16 bits: handshake statistics (see Configuration).

Function
REQ-014 SHALL keep one 4-bit persistence counter per bit i: threat_vector[i]=1 increments it, saturating at PERSIST; threat_vector[i]=0 clears it to 0.
REQ-015 SHALL set confirmed[i] on the same edge its counter reaches PERSIST; confirmed[i] SHALL clear on the edge the counter clears.
REQ-016 SHALL set pending[i] only on a 0->1 transition of confirmed[i]; a bit held high beyond PERSIST samples SHALL NOT re-arm pending.
REQ-017 In IDLE with pending!=0, the FSM SHALL select the lowest set index of pending (bit 0 has highest priority), load it into cm_code, and enter DISPATCH on the next edge, asserting cm_valid.
REQ-018 In DISPATCH, cm_valid SHALL stay 1 and cm_code SHALL stay stable until a cycle with cm_valid=1 and cm_ready=1 (handshake).
REQ-019 On handshake, the FSM SHALL clear pending[cm_code], deassert cm_valid, load the cooldown counter with COOLDOWN, and enter COOLDOWN.
REQ-020 COOLDOWN SHALL last exactly COOLDOWN cycles, then return to IDLE; pending SHALL keep accumulating during COOLDOWN and DISPATCH.
REQ-021 When a pending set for index k and a handshake clear for the same index k occur on the same edge, the set SHALL win and pending[k] SHALL remain 1.
REQ-022 Higher-priority bits that become pending during DISPATCH SHALL NOT pre-empt the command in flight.
REQ-023 cm_ready while cm_valid=0 SHALL have no effect.
REQ-024 alert SHALL equal the OR of confirmed delayed by one cycle.
REQ-025 From a first threat sample at edge N, the critical-path latency SHALL be: confirmed and pending high after edge N+PERSIST-1, and cm_valid high after edge N+PERSIST (FSM in IDLE).

Reset
REQ-026 Asserting reset SHALL immediately clear: all persistence counters, confirmed, pending, alert, cm_valid, cm_code, dispatch_count, and the cooldown counter; state SHALL go to IDLE.
REQ-027 A reset during DISPATCH or COOLDOWN SHALL abort the command without a handshake; after reset deasserts, no command SHALL issue until a new confirmation occurs.

Configuration
REQ-028 With macro THREAT_STATS_EN defined, dispatch_count SHALL increment by 1 on each handshake and saturate at 16'hFFFF.
REQ-029 Without THREAT_STATS_EN, dispatch_count SHALL be tied to 16'h0000 and no counter logic SHALL be instantiated.

Verification
REQ-030 Persistence: PERSIST=3; threat_vector=8'h01 for 2 cycles, then 8'h00 -> confirmed stays 0 and cm_valid is never asserted; then 3 cycles of 8'h01 -> confirmed[0]=1 after the 3rd edge, cm_valid=1 and cm_code=0 one edge later.
REQ-031 Priority and stall: threat_vector=8'h88 held, cm_ready=0 -> cm_code=3 with cm_valid held; cm_ready=1 after 5 cycles -> pending=8'h80, state=COOLDOWN for 8 cycles, then cm_code=7 is dispatched.
REQ-032 Same-edge set/clear: during a handshake clearing index 2, drive confirmed[2] low then high so its rising edge coincides with the handshake -> pending[2] stays 1 and is re-dispatched after COOLDOWN.
REQ-033 Reset mid-operation: assert reset in DISPATCH with pending=8'h06 -> cm_valid=0, pending=0, state=IDLE, all immediately without a clock edge.
REQ-034 Statistics: with THREAT_STATS_EN, perform 3 handshakes -> dispatch_count=3; without the macro -> dispatch_count=0 throughout.
